wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writers:
  - the pipeline writeback stream, which comes from the MEM/WB register;
  - a multi-cycle multiply/divide unit (MDU), which returns results out of band.
- Buffers MDU results in a small FIFO and drains them into idle writeback slots.
- Forces a one-cycle W-stage stall when the FIFO is full or its head has waited too long.
- Exports busy flags so the hazard unit can stall decode on registers with pending writes.

---
 rtl/wb_port_arbiter.sv | 113 +++++++++++
 tb/tb_wb_port_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between W-stage writeback and MDU results
// MDU results queue in a small FIFO and drain into idle slots, or force a one-cycle W stall.
module wb_port_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_addr,
   input  logic [31:0] pipe_data,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_addr,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   output logic        stall_w,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic        busy_rs,
   output logic        busy_rt
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    age_q, age_d;
   logic [4:0]    addr_q [DEPTH];
   logic [4:0]    addr_d [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];

   logic          pipe_eff, full, forced, pop, push, push_wr;
   logic          hit_rs, hit_rt;
   logic [PW-1:0] rel;

   always_comb begin
      pipe_eff  = pipe_we && (pipe_addr != 5'd0);
      full      = (count_q == CW'(DEPTH));
      forced    = full || ((count_q != '0) && (age_q >= 4'(MAX_WAIT)));
      pop       = forced || ((count_q != '0) && !pipe_eff);
      mdu_ready = rst_n && !full;
      push      = mdu_valid && mdu_ready;
      push_wr   = push && (mdu_addr != 5'd0);
      stall_w   = rst_n && forced;

      if (pop) begin
         rf_we   = rst_n;
         rf_addr = addr_q[rd_ptr_q];
         rf_data = data_q[rd_ptr_q];
      end else begin
         rf_we   = rst_n && pipe_eff;
         rf_addr = pipe_addr;
         rf_data = pipe_data;
      end

      // A slot is live when its distance from the head is below count; the head stays busy while popping.
      hit_rs = push && (mdu_addr == rs_addr);
      hit_rt = push && (mdu_addr == rt_addr);
      rel    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rel = PW'(i) - rd_ptr_q;
         if (CW'(rel) < count_q) begin
            if (addr_q[i] == rs_addr) hit_rs = 1'b1;
            if (addr_q[i] == rt_addr) hit_rt = 1'b1;
         end
      end
      busy_rs = rst_n && hit_rs && (rs_addr != 5'd0);
      busy_rt = rst_n && hit_rt && (rt_addr != 5'd0);

      addr_d = addr_q;
      data_d = data_q;
      if (push_wr) begin
         addr_d[wr_ptr_q] = mdu_addr;
         data_d[wr_ptr_q] = mdu_data;
      end
      wr_ptr_d = wr_ptr_q + PW'(push_wr);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push_wr) - CW'(pop);

      if (pop || (count_q == '0))
         age_d = 4'd0;
      else if (age_q < 4'(MAX_WAIT))
         age_d = age_q + 4'd1;
      else
         age_d = age_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         age_q    <= 4'd0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= 5'd0;
            data_q[i] <= 32'd0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         age_q    <= age_d;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_we, mdu_valid, mdu_ready, rf_we, stall_w, busy_rs, busy_rt;
   logic [4:0]  pipe_addr, mdu_addr, rf_addr, rs_addr, rt_addr;
   logic [31:0] pipe_data, mdu_data, rf_data;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q [$];
   wr_t mon_e;
   int  total = 0;
   int  bad   = 0;

   wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
      .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .stall_w(stall_w),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .busy_rs(busy_rs), .busy_rt(busy_rt)
   );

   always #5 clk = ~clk;

   // Every RF write must match the next expected write, in order.
   always @(negedge clk) begin
      if (rf_we) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rf_unexpected: got addr=%0d data=%h, required no write", rf_addr, rf_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({rf_addr, rf_data} !== {mon_e.a, mon_e.d}) begin
               bad++;
               $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                        rf_addr, rf_data, mon_e.a, mon_e.d);
            end
         end
      end
   end

   task automatic idle_inputs;
      pipe_we = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
      mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      pipe_we = 1'b1; pipe_addr = 5'd8; pipe_data = 32'h77;
      mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h99;
      rs_addr = 5'd9; rt_addr = 5'd9;
      @(negedge clk);
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b required 0", rf_we); end
      total++; if (stall_w !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b required 0", stall_w); end
      total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b required 0", mdu_ready); end
      total++; if ({busy_rs, busy_rt} !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b%b required 00", busy_rs, busy_rt); end
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b required 1", mdu_ready); end
      total++; if (stall_w !== 1'b0) begin bad++; $display("FAIL release_stall: got %b required 0", stall_w); end
      @(posedge clk); #1;
   endtask

   task automatic test_pipe_write;
      pipe_we = 1'b1; pipe_addr = 5'd8; pipe_data = 32'h11;
      exp_q.push_back({5'd8, 32'h11});
      @(negedge clk);
      total++; if (stall_w !== 1'b0) begin bad++; $display("FAIL pipe_stall: got %b required 0", stall_w); end
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL pipe_ready: got %b required 1", mdu_ready); end
      @(posedge clk); #1;
      idle_inputs();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pipe_pending: got %0d left required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_opportunistic;
      rs_addr = 5'd9;
      mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hA5;
      @(negedge clk);
      total++; if (busy_rs !== 1'b1) begin bad++; $display("FAIL opp_busy_push: got %b required 1", busy_rs); end
      @(posedge clk); #1;
      idle_inputs();
      exp_q.push_back({5'd9, 32'hA5});
      @(negedge clk);
      total++; if (stall_w !== 1'b0) begin bad++; $display("FAIL opp_stall: got %b required 0", stall_w); end
      total++; if (busy_rs !== 1'b1) begin bad++; $display("FAIL opp_busy_pop: got %b required 1", busy_rs); end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (busy_rs !== 1'b0) begin bad++; $display("FAIL opp_busy_after: got %b required 0", busy_rs); end
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL opp_ready: got %b required 1", mdu_ready); end
      @(posedge clk); #1;
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL opp_pending: got %0d left required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_forced_age;
      logic [31:0] d;
      d = 32'h100;
      rs_addr = 5'd5;
      for (int c = 0; c < 8; c++) begin
         pipe_we = 1'b1; pipe_addr = 5'd10; pipe_data = d;
         mdu_valid = (c == 0); mdu_addr = 5'd5; mdu_data = 32'h55;
         if (c == 5) exp_q.push_back({5'd5, 32'h55});
         else exp_q.push_back({5'd10, d});
         @(negedge clk);
         total++; if (stall_w !== (c == 5)) begin bad++; $display("FAIL age_stall c=%0d: got %b required %b", c, stall_w, c == 5); end
         total++; if (busy_rs !== (c <= 5)) begin bad++; $display("FAIL age_busy c=%0d: got %b required %b", c, busy_rs, c <= 5); end
         @(posedge clk); #1;
         if (c != 5) d = d + 32'd1;
      end
      idle_inputs();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL age_pending: got %0d left required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_full;
      logic [31:0] d;
      d = 32'h200;
      rs_addr = 5'd3; rt_addr = 5'd4;
      for (int c = 0; c < 9; c++) begin
         pipe_we = 1'b1; pipe_addr = 5'd11; pipe_data = d;
         mdu_valid = (c < 2);
         mdu_addr = (c == 0) ? 5'd3 : 5'd4;
         mdu_data = (c == 0) ? 32'h33 : 32'h44;
         if (c == 2) exp_q.push_back({5'd3, 32'h33});
         else if (c == 7) exp_q.push_back({5'd4, 32'h44});
         else exp_q.push_back({5'd11, d});
         @(negedge clk);
         total++; if (stall_w !== (c == 2 || c == 7)) begin bad++; $display("FAIL full_stall c=%0d: got %b required %b", c, stall_w, c == 2 || c == 7); end
         total++; if (mdu_ready !== (c != 2)) begin bad++; $display("FAIL full_ready c=%0d: got %b required %b", c, mdu_ready, c != 2); end
         total++; if (busy_rs !== (c <= 2)) begin bad++; $display("FAIL full_busy_rs c=%0d: got %b required %b", c, busy_rs, c <= 2); end
         total++; if (busy_rt !== (c >= 1 && c <= 7)) begin bad++; $display("FAIL full_busy_rt c=%0d: got %b required %b", c, busy_rt, c >= 1 && c <= 7); end
         @(posedge clk); #1;
         if (c != 2 && c != 7) d = d + 32'd1;
      end
      idle_inputs();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_pending: got %0d left required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_zero_addr;
      rs_addr = 5'd0; rt_addr = 5'd0;
      for (int c = 0; c < 3; c++) begin
         pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hDEAD;
         mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'hBEEF;
         @(negedge clk);
         total++; if (busy_rs !== 1'b0) begin bad++; $display("FAIL zero_busy c=%0d: got %b required 0", c, busy_rs); end
         total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL zero_ready c=%0d: got %b required 1", c, mdu_ready); end
         total++; if (stall_w !== 1'b0) begin bad++; $display("FAIL zero_stall c=%0d: got %b required 0", c, stall_w); end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid;
      rs_addr = 5'd7; rt_addr = 5'd6;
      for (int c = 0; c < 2; c++) begin
         pipe_we = 1'b1; pipe_addr = 5'd12; pipe_data = 32'h300 + c;
         mdu_valid = 1'b1;
         mdu_addr = (c == 0) ? 5'd6 : 5'd7;
         mdu_data = (c == 0) ? 32'h66 : 32'h77;
         exp_q.push_back({5'd12, 32'h300 + c});
         @(posedge clk); #1;
      end
      mdu_valid = 1'b0; pipe_data = 32'h302;
      exp_q.push_back({5'd6, 32'h66});
      @(negedge clk);
      total++; if (stall_w !== 1'b1) begin bad++; $display("FAIL mid_stall_before: got %b required 1", stall_w); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (stall_w !== 1'b0) begin bad++; $display("FAIL mid_stall_reset: got %b required 0", stall_w); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_rf_we_reset: got %b required 0", rf_we); end
      total++; if ({busy_rs, busy_rt} !== 2'b00) begin bad++; $display("FAIL mid_busy_reset: got %b%b required 00", busy_rs, busy_rt); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_inputs();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++; if (busy_rs !== 1'b0) begin bad++; $display("FAIL mid_busy_after c=%0d: got %b required 0", c, busy_rs); end
         total++; if (stall_w !== 1'b0) begin bad++; $display("FAIL mid_stall_after c=%0d: got %b required 0", c, stall_w); end
         @(posedge clk); #1;
      end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_pending: got %0d left required 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      idle_inputs();
      rs_addr = 5'd0; rt_addr = 5'd0;
      test_reset();
      test_pipe_write();
      test_opportunistic();
      test_forced_age();
      test_full();
      test_zero_addr();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
